// File: rtl/pipelined_datapath.sv
// Three-stage (EX, MEM, WB) datapath with its own register file and ALU, resolving RAW hazards.
// Define PIPELINED_DATAPATH_FORWARDING_EN to enable the EX/MEM and MEM/WB bypass paths.
module pipelined_datapath #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic [REG_AW-1:0] rd,
  input  logic              reg_dst,
  input  logic              alu_src,
  input  logic              mem_to_reg,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              reg_write,
  input  logic              imm_zext,
  input  logic [3:0]        alu_op,
  input  logic [15:0]       immediate,
  output logic [WIDTH-1:0]  data_address,
  output logic [WIDTH-1:0]  data_writedata,
  output logic              data_read,
  output logic              data_write,
  input  logic [WIDTH-1:0]  data_readdata,
  input  logic              data_waitrequest,
  output logic [WIDTH-1:0]  reg_read_data_0,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_addr,
  output logic [WIDTH-1:0]  wb_data
);
  localparam int SHW  = $clog2(WIDTH);
  localparam int NREG = 2**REG_AW;

  logic [WIDTH-1:0]  regs [NREG];

  logic              exm_valid, exm_reg_write, exm_mem_read, exm_mem_write, exm_mem_to_reg;
  logic [REG_AW-1:0] exm_waddr;
  logic [WIDTH-1:0]  exm_alu, exm_rt_val;

  logic              mwb_valid, mwb_reg_write;
  logic [REG_AW-1:0] mwb_waddr;
  logic [WIDTH-1:0]  mwb_data;

  logic                   freeze, rf_we, accept;
  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0][WIDTH-1:0]  src_val;
  logic [1:0]             src_hazard;
  logic [WIDTH-1:0]       imm_ext, op1, op2, alu_res;
  logic [SHW-1:0]         shamt;
  logic signed [15:0]     imm_s;

  // A pending memory access that is not yet acknowledged holds both back stages.
  assign freeze   = data_waitrequest && (data_read || data_write);
  assign wb_valid = mwb_valid && mwb_reg_write && !freeze;
  assign wb_addr  = mwb_waddr;
  assign wb_data  = mwb_data;
  assign rf_we    = wb_valid && (mwb_waddr != '0);
  assign in_ready = !freeze && !(|src_hazard);
  assign accept   = in_valid && in_ready;

  assign data_address   = exm_alu;
  assign data_writedata = exm_rt_val;
  assign data_read      = exm_valid && exm_mem_read;
  assign data_write     = exm_valid && exm_mem_write;

  assign src_addr = {rt, rs};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      logic             exm_match, mwb_match;
      logic [WIDTH-1:0] rf_val;
      assign exm_match = (src_addr[gi] != '0) && exm_valid && exm_reg_write &&
                         (exm_waddr == src_addr[gi]);
      assign mwb_match = (src_addr[gi] != '0) && mwb_valid && mwb_reg_write &&
                         (mwb_waddr == src_addr[gi]);
      // Write-through: a read of the entry being written this cycle sees the new value.
      assign rf_val = (src_addr[gi] == '0) ? '0 :
                      (rf_we && (mwb_waddr == src_addr[gi])) ? mwb_data : regs[src_addr[gi]];
`ifdef PIPELINED_DATAPATH_FORWARDING_EN
      assign src_val[gi]    = (exm_match && !exm_mem_read) ? exm_alu :
                              mwb_match ? mwb_data : rf_val;
      assign src_hazard[gi] = exm_match && exm_mem_read;
`else
      assign src_val[gi]    = rf_val;
      assign src_hazard[gi] = exm_match || mwb_match;
`endif
    end
  endgenerate

  assign reg_read_data_0 = src_val[0];
  assign imm_s           = immediate;

  always_comb begin
    if (imm_zext) imm_ext = WIDTH'(immediate);
    else          imm_ext = WIDTH'(imm_s);
  end

  assign op1   = src_val[0];
  assign op2   = alu_src ? src_val[1] : imm_ext;
  assign shamt = op2[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0:    alu_res = op1 + op2;
      4'd1:    alu_res = op1 - op2;
      4'd2:    alu_res = op1 & op2;
      4'd3:    alu_res = op1 | op2;
      4'd4:    alu_res = op1 ^ op2;
      4'd5:    alu_res = {{(WIDTH-1){1'b0}}, ($signed(op1) < $signed(op2))};
      4'd6:    alu_res = {{(WIDTH-1){1'b0}}, (op1 < op2)};
      4'd7:    alu_res = op1 << shamt;
      4'd8:    alu_res = op1 >> shamt;
      4'd9:    alu_res = $unsigned($signed(op1) >>> shamt);
      4'd10:   alu_res = WIDTH'({immediate, 16'h0000});
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      exm_valid      <= 1'b0;
      exm_reg_write  <= 1'b0;
      exm_mem_read   <= 1'b0;
      exm_mem_write  <= 1'b0;
      exm_mem_to_reg <= 1'b0;
      exm_waddr      <= '0;
      exm_alu        <= '0;
      exm_rt_val     <= '0;
    end else if (!freeze) begin
      // No accept means a bubble; payload fields are left stale behind a cleared valid.
      exm_valid <= accept;
      if (accept) begin
        exm_reg_write  <= reg_write;
        exm_mem_read   <= mem_read;
        exm_mem_write  <= mem_write;
        exm_mem_to_reg <= mem_to_reg;
        exm_waddr      <= reg_dst ? rd : rt;
        exm_alu        <= alu_res;
        exm_rt_val     <= src_val[1];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mwb_valid     <= 1'b0;
      mwb_reg_write <= 1'b0;
      mwb_waddr     <= '0;
      mwb_data      <= '0;
    end else if (!freeze) begin
      mwb_valid     <= exm_valid;
      mwb_reg_write <= exm_reg_write;
      mwb_waddr     <= exm_waddr;
      mwb_data      <= exm_mem_to_reg ? data_readdata : exm_alu;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (rf_we) begin
      regs[mwb_waddr] <= mwb_data;
    end
  end
endmodule

// File: tb/tb_pipelined_datapath.sv
// Self-checking bench for pipelined_datapath: program-order reference model, directed and random stimulus.
module tb_pipelined_datapath;
  typedef struct packed {
    logic [4:0] rs, rt, rd;
    logic reg_dst, alu_src, mem_to_reg, mem_read, mem_write, reg_write, imm_zext;
    logic [3:0] op;
    logic [15:0] imm;
  } ins_t;
  typedef struct packed { logic [4:0] a; logic [31:0] d; } wb_t;
  typedef struct packed { logic w; logic [31:0] a; logic [31:0] d; } mem_t;

`ifdef PIPELINED_DATAPATH_FORWARDING_EN
  localparam int STALL_DEP = 0;
  localparam int STALL_LD  = 1;
`else
  localparam int STALL_DEP = 2;
  localparam int STALL_LD  = 2;
`endif

  logic clk = 1'b0;
  logic reset;
  logic in_valid, in_ready;
  logic [4:0] rs, rt, rd;
  logic reg_dst, alu_src, mem_to_reg, mem_read, mem_write, reg_write, imm_zext;
  logic [3:0] alu_op;
  logic [15:0] immediate;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic data_read, data_write, data_waitrequest;
  logic [31:0] reg_read_data_0;
  logic wb_valid;
  logic [4:0] wb_addr;
  logic [31:0] wb_data;

  pipelined_datapath #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs(rs), .rt(rt), .rd(rd), .reg_dst(reg_dst), .alu_src(alu_src),
    .mem_to_reg(mem_to_reg), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .imm_zext(imm_zext), .alu_op(alu_op), .immediate(immediate),
    .data_address(data_address), .data_writedata(data_writedata),
    .data_read(data_read), .data_write(data_write), .data_readdata(data_readdata),
    .data_waitrequest(data_waitrequest), .reg_read_data_0(reg_read_data_0),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data));

  always #5 clk = ~clk;

  // External data memory, word-indexed by address bits [9:2].
  logic [31:0] mem [256];
  assign data_readdata = mem[data_address[9:2]];
  always @(posedge clk) begin
    if (!reset) for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
    else if (data_write && !data_waitrequest) mem[data_address[9:2]] <= data_writedata;
  end

  int n_checks = 0;
  int n_pass = 0;
  logic chk_en = 1'b0;
  logic rand_wait = 1'b0;
  logic [31:0] mreg [32];
  logic [31:0] mmem [256];
  wb_t  exp_wb[$], wb_log[$];
  mem_t exp_mem[$], mem_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [31:0] alu_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [15:0] imm);
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      4'd10: return {imm, 16'h0000};
      default: return 32'h0;
    endcase
  endfunction

  function automatic ins_t mk_alu(input logic [3:0] op, input logic [4:0] s, input logic [4:0] t,
                                  input logic [4:0] d, input logic rdst, input logic asrc,
                                  input logic [15:0] imm, input logic zx);
    ins_t i;
    i = '0;
    i.op = op; i.rs = s; i.rt = t; i.rd = d; i.reg_dst = rdst; i.alu_src = asrc;
    i.imm = imm; i.imm_zext = zx; i.reg_write = 1'b1;
    return i;
  endfunction

  function automatic ins_t mk_ld(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    ins_t i;
    i = mk_alu(4'd0, s, t, 5'd0, 1'b0, 1'b0, imm, 1'b0);
    i.mem_read = 1'b1; i.mem_to_reg = 1'b1;
    return i;
  endfunction

  function automatic ins_t mk_st(input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    ins_t i;
    i = mk_alu(4'd0, s, t, 5'd0, 1'b0, 1'b0, imm, 1'b0);
    i.mem_write = 1'b1; i.reg_write = 1'b0;
    return i;
  endfunction

  // Architectural effect of one instruction, executed strictly in program order.
  task automatic model_accept(input ins_t i);
    logic [31:0] a, bt, b, ie, res, v;
    logic [4:0] dst;
    mem_t me;
    wb_t we;
    a  = mreg[i.rs];
    bt = mreg[i.rt];
    ie = i.imm_zext ? {16'h0, i.imm} : {{16{i.imm[15]}}, i.imm};
    b  = i.alu_src ? bt : ie;
    res = alu_model(i.op, a, b, i.imm);
    chk("rs_value", reg_read_data_0, a);
    v = res;
    if (i.mem_write) begin
      mmem[res[9:2]] = bt;
      me.w = 1'b1; me.a = res; me.d = bt; exp_mem.push_back(me);
    end
    if (i.mem_read) begin
      me.w = 1'b0; me.a = res; me.d = 32'h0; exp_mem.push_back(me);
      if (i.mem_to_reg) v = mmem[res[9:2]];
    end
    dst = i.reg_dst ? i.rd : i.rt;
    if (i.reg_write) begin
      we.a = dst; we.d = v; exp_wb.push_back(we);
      if (dst != 5'd0) mreg[dst] = v;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_wait) data_waitrequest = ($urandom_range(0, 3) == 0);
  endtask

  task automatic send(input ins_t i, output int stalls);
    stalls = 0;
    rs = i.rs; rt = i.rt; rd = i.rd; reg_dst = i.reg_dst; alu_src = i.alu_src;
    mem_to_reg = i.mem_to_reg; mem_read = i.mem_read; mem_write = i.mem_write;
    reg_write = i.reg_write; imm_zext = i.imm_zext; alu_op = i.op; immediate = i.imm;
    in_valid = 1'b1;
    for (int c = 0; c < 64; c++) begin
      @(negedge clk);
      if (in_ready) begin
        model_accept(i);
        tick();
        in_valid = 1'b0;
        return;
      end
      stalls++;
      tick();
    end
    chk("accept_timeout", {31'h0, in_ready}, 32'd1);
    in_valid = 1'b0;
  endtask

  always @(negedge clk) begin : cmp
    wb_t we, wo;
    mem_t me, mo;
    if (chk_en) begin
      if (wb_valid) begin
        wo.a = wb_addr; wo.d = wb_data; wb_log.push_back(wo);
        if (exp_wb.size() == 0) chk("wb_unexpected", {31'h0, wb_valid}, 32'd0);
        else begin
          we = exp_wb.pop_front();
          chk("wb_addr", {27'h0, wb_addr}, {27'h0, we.a});
          chk("wb_data", wb_data, we.d);
        end
      end
      if ((data_read || data_write) && !data_waitrequest) begin
        mo.w = data_write; mo.a = data_address; mo.d = data_writedata; mem_log.push_back(mo);
        if (exp_mem.size() == 0) chk("mem_unexpected", {31'h0, data_read | data_write}, 32'd0);
        else begin
          me = exp_mem.pop_front();
          chk("mem_kind", {31'h0, data_write}, {31'h0, me.w});
          chk("mem_addr", data_address, me.a);
          if (me.w) chk("mem_wdata", data_writedata, me.d);
        end
      end
    end
  end

  initial begin
    int st;
    ins_t ri;
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
    reset = 1'b0; in_valid = 1'b1; rs = 5'd3; rt = 5'd4; rd = 5'd5;
    reg_dst = 1'b0; alu_src = 1'b0; mem_to_reg = 1'b0; mem_read = 1'b1; mem_write = 1'b0;
    reg_write = 1'b1; imm_zext = 1'b0; alu_op = 4'd0; immediate = 16'h0040;
    data_waitrequest = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", {31'h0, in_ready}, 32'd1);
    chk("rst_data_read", {31'h0, data_read}, 32'd0);
    chk("rst_data_write", {31'h0, data_write}, 32'd0);
    chk("rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    chk("rst_data_address", data_address, 32'h0);
    chk("rst_wb_data", wb_data, 32'h0);
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0; mem_read = 1'b0;
    chk_en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      rs = i[4:0];
      @(negedge clk);
      chk("rst_reg_read", reg_read_data_0, 32'h0);
    end
    tick();

    // Dependent ALU pair
    send(mk_alu(4'd0, 5'd0, 5'd1, 5'd0, 1'b0, 1'b0, 16'd5, 1'b0), st);
    send(mk_alu(4'd0, 5'd1, 5'd1, 5'd2, 1'b1, 1'b1, 16'd0, 1'b0), st);
    chk("dep_stalls", st, STALL_DEP);
    // Store, load, load-use
    send(mk_st(5'd0, 5'd2, 16'h0040), st);
    send(mk_ld(5'd0, 5'd3, 16'h0040), st);
    send(mk_alu(4'd0, 5'd3, 5'd4, 5'd0, 1'b0, 1'b0, 16'd1, 1'b0), st);
    chk("load_use_stalls", st, STALL_LD);
    repeat (5) tick();
    chk("wb_log_size_a", wb_log.size(), 4);
    if (wb_log.size() >= 4) begin
      chk("wb_r1", wb_log[0].d, 32'd5);
      chk("wb_r2", wb_log[1].d, 32'd10);
      chk("wb_r3", wb_log[2].d, 32'd10);
      chk("wb_r4", wb_log[3].d, 32'd11);
    end
    if (mem_log.size() >= 1) begin
      chk("st_kind", {31'h0, mem_log[0].w}, 32'd1);
      chk("st_addr", mem_log[0].a, 32'h40);
      chk("st_data", mem_log[0].d, 32'd10);
    end

    // r0 write, immediates, shifts and compares
    send(mk_alu(4'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 16'hFFFF, 1'b0), st);
    send(mk_alu(4'd3, 5'd0, 5'd5, 5'd0, 1'b0, 1'b0, 16'hFFFF, 1'b1), st);
    send(mk_alu(4'd10, 5'd0, 5'd6, 5'd0, 1'b0, 1'b0, 16'h8000, 1'b0), st);
    send(mk_alu(4'd9, 5'd6, 5'd7, 5'd0, 1'b0, 1'b0, 16'd4, 1'b0), st);
    send(mk_alu(4'd5, 5'd7, 5'd5, 5'd8, 1'b1, 1'b1, 16'd0, 1'b0), st);
    send(mk_alu(4'd6, 5'd7, 5'd5, 5'd9, 1'b1, 1'b1, 16'd0, 1'b0), st);

    // Three wait-state cycles on a load
    send(mk_ld(5'd0, 5'd10, 16'h0040), st);
    data_waitrequest = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("ws_in_ready", {31'h0, in_ready}, 32'd0);
      chk("ws_wb_valid", {31'h0, wb_valid}, 32'd0);
      chk("ws_data_read", {31'h0, data_read}, 32'd1);
      chk("ws_addr", data_address, 32'h40);
      tick();
    end
    data_waitrequest = 1'b0;
    repeat (5) tick();
    chk("wb_log_size_b", wb_log.size(), 11);
    if (wb_log.size() >= 11) begin
      chk("wb_r0_addr", {27'h0, wb_log[4].a}, 32'd0);
      chk("wb_r0_data", wb_log[4].d, 32'hFFFFFFFF);
      chk("wb_ori", wb_log[5].d, 32'h0000FFFF);
      chk("wb_lui", wb_log[6].d, 32'h80000000);
      chk("wb_sra", wb_log[7].d, 32'hF8000000);
      chk("wb_slt", wb_log[8].d, 32'd1);
      chk("wb_sltu", wb_log[9].d, 32'd0);
      chk("wb_ws_load", wb_log[10].d, 32'd10);
    end
    chk("ws_load_once", mem_log.size(), 3);

    // Randomized program with random wait states
    rand_wait = 1'b1;
    for (int n = 0; n < 300; n++) begin
      int kind;
      kind = $urandom_range(0, 9);
      if (kind <= 5) begin
        ri = mk_alu(4'($urandom_range(0, 15)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    16'($urandom), 1'($urandom_range(0, 1)));
        ri.reg_write = ($urandom_range(0, 9) != 0);
      end else if (kind <= 7) begin
        ri = mk_ld(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 1023)));
      end else if (kind == 8) begin
        ri = mk_st(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 16'($urandom_range(0, 1023)));
      end else begin
        tick();
        continue;
      end
      send(ri, st);
    end
    rand_wait = 1'b0;
    data_waitrequest = 1'b0;
    repeat (6) tick();
    chk("drain_wb", exp_wb.size(), 0);
    chk("drain_mem", exp_mem.size(), 0);

    // Reset while a load is in MEM
    send(mk_ld(5'd0, 5'd7, 16'h0040), st);
    chk("pre_rst_read", {31'h0, data_read}, 32'd1);
    chk_en = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("async_rst_read", {31'h0, data_read}, 32'd0);
    chk("async_rst_write", {31'h0, data_write}, 32'd0);
    chk("async_rst_wb_valid", {31'h0, wb_valid}, 32'd0);
    chk("async_rst_in_ready", {31'h0, in_ready}, 32'd1);
    exp_wb.delete();
    exp_mem.delete();
    for (int i = 0; i < 32; i++) mreg[i] = 32'h0;
    for (int i = 0; i < 256; i++) mmem[i] = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    chk_en = 1'b1;
    send(mk_alu(4'd0, 5'd7, 5'd11, 5'd0, 1'b0, 1'b0, 16'd3, 1'b0), st);
    repeat (4) tick();
    chk("post_rst_wb_drain", exp_wb.size(), 0);
    chk("post_rst_no_mem", exp_mem.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/pipelined_datapath.md
# pipelined_datapath

Parametrised three-stage (EX, MEM, WB) successor to the single-cycle Harvard datapath. It accepts decoded instruction fields and control from the decoder, and contains its own register file and ALU. It resolves read-after-write hazards by forwarding or stalling, and freezes on data-memory wait states. It sits between the control/decode unit and the data-memory port of the Harvard CPU.

## Interface
- WIDTH, 32, datapath and register width (≥16)
- REG_AW, 5, register address width; register file has 2**REG_AW entries, entry 0 reads zero
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction fields below are valid
- in_ready  out  1  instruction accepted on this edge when in_valid && in_ready
- rs, rt, rd  in  REG_AW each  source/dest register addresses
- reg_dst, alu_src, mem_to_reg, mem_read, mem_write, reg_write, imm_zext  in  1 each  control; alu_src=1 selects register rt as op2, 0 the extended immediate
- alu_op  in  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLTU, 7 SLL, 8 SRL, 9 SRA, 10 LUI; others yield 0
- immediate  in  16  instruction immediate
- data_address, data_writedata  out  WIDTH each  memory address / store data
- data_read, data_write  out  1 each  memory strobes
- data_readdata  in  WIDTH  combinational read data, valid in the cycle data_read is high and data_waitrequest is low
- data_waitrequest  in  1  memory not ready; holds the pipeline
- reg_read_data_0  out  WIDTH  forwarded rs value of the instruction being accepted
- wb_valid, wb_addr, wb_data  out  1, REG_AW, WIDTH  register write occurring on the next edge

## Operation
- EX (combinational on inputs): read rs/rt with forwarding, extend the immediate (sign-extend unless imm_zext) to WIDTH, compute the ALU result. Write address is rd if reg_dst, else rt. The result is captured into the EX/MEM register on accept.
- SLT/SLTU produce 1/0. Shifts use op2[log2(WIDTH)-1:0] as shift amount on op1. LUI = immediate << 16. ADD/SUB wrap modulo 2**WIDTH.
- MEM: data_address = EX/MEM ALU result; data_writedata = EX/MEM rt value; strobes = EX/MEM mem_read/mem_write gated by the stage-valid bit.
- Captured into MEM/WB: data_readdata if mem_to_reg, else the ALU result.
- WB: the register file is written from MEM/WB when valid, reg_write is set, and the address is nonzero. wb_* outputs mirror MEM/WB.
- Register-file read of an address being written in the same cycle returns the new value (write-through).
- Forwarding priority for rs/rt (nonzero address only): EX/MEM (non-load) > MEM/WB > register file.
- Load-use hazard: an EX/MEM load whose destination matches a nonzero rs or rt of the incoming instruction drives in_ready=0 for one cycle and inserts a bubble into EX/MEM.
- Wait state: data_waitrequest=1 while a strobe is high freezes EX/MEM and MEM/WB. A bubble enters MEM/WB only when no strobe is active. in_ready=0 and wb_valid=0 during the freeze.

## Timing
- Accept at edge N → MEM during cycle N+1 → register write at edge N+2. Back-to-back dependent ALU ops incur no stall with forwarding.
- Load followed by a dependent instruction costs exactly 1 stall cycle, plus any wait-state cycles.
- reset low: all stage-valid bits cleared and all registers/regfile entries zeroed immediately. Outputs: in_ready=1, strobes=0, wb_valid=0, and all data outputs 0.
- Reset asserted mid-operation discards in-flight instructions. No memory strobe is issued after reset asserts.
- Simultaneous stall and wait state: the wait state dominates and no bubble is inserted until it clears.

## Configuration
- PIPELINED_DATAPATH_FORWARDING_EN defined: forwarding as above.
- Undefined: no bypass paths except regfile write-through. in_ready=0 whenever a nonzero rs/rt matches a valid writing destination in EX/MEM or MEM/WB, so a dependent ALU op waits 2 cycles.

## Test plan
- Reset: hold reset low with in_valid=1 → in_ready=1, data_read=data_write=0, wb_valid=0; all register reads return 0 after release.
- ADD r1=r0+imm 5, then ADD r2=r1+r1 back-to-back → no stall, wb_data 5 then 10; without the macro, 2 stall cycles and the same results.
- Store r2 (10) to address 0x40, then load r3 from 0x40 returning 10, then ADD r4=r3+1 → data_write at 0x40 with data 10; in_ready low 1 cycle; wb_data 11.
- data_waitrequest high 3 cycles during a load → in_ready=0 and wb_valid=0 for 3 cycles, address held, load completes once.
- Write to r0 with immediate 0xFFFF sign-extended → wb_valid=1, and a later read of r0 returns 0. With imm_zext, ORI to r5 → 0x0000FFFF.
- Assert reset with a load in MEM → data_read drops asynchronously and no write occurs.
